// File: rtl/input_capture_pkg.sv
// Shared types and sizing helpers for the switch/button input capture path.
package input_capture_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int DEPTH_DEF  = 4;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   // Counter width able to hold 0..n.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes the raw button and switches, debounces the button and emits
// one registered press_evt per accepted press.
module btn_debounce
   import input_capture_pkg::*;
#(
   parameter int DATA_W          = DATA_W_DEF,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              btn_n,
   input  logic [DATA_W-1:0] switches_raw,
   output logic              press_evt,
   output logic              level,
   output logic [DATA_W-1:0] sw_sync
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // The button chain carries the inverted level so a cleared chain reads
   // as "released" straight out of reset.
   logic [SYNC_STAGES-1:0]             btn_pipe;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_pipe;
   logic                               btn_s;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         btn_pipe <= '0;
         sw_pipe  <= '0;
      end else begin
         btn_pipe <= {btn_pipe[SYNC_STAGES-2:0], ~btn_n};
         sw_pipe  <= {sw_pipe[SYNC_STAGES-2:0], switches_raw};
      end
   end

   assign btn_s   = btn_pipe[SYNC_STAGES-1];
   assign sw_sync = sw_pipe[SYNC_STAGES-1];

   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             evt_d;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         press_evt <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_evt <= evt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
      case (state_q)
         RELEASED: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               evt_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   assign level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/input_capture.sv
// Captures the switch word on each debounced press into a small FIFO and
// hands words to the control unit through a ready/request/valid handshake.
module input_capture
   import input_capture_pkg::*;
#(
   parameter int DATA_W          = DATA_W_DEF,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DEPTH           = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   btn_n,
   input  logic [DATA_W-1:0]      switches_raw,
   input  logic                   rd_req,
   input  logic                   clr_ovf,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid,
   output logic                   ready,
   output logic                   full,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic              press_evt;
   logic [DATA_W-1:0] sw_sync;

   btn_debounce #(
      .DATA_W          (DATA_W),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk          (clk),
      .n_reset      (n_reset),
      .btn_n        (btn_n),
      .switches_raw (switches_raw),
      .press_evt    (press_evt),
      .level        (),
      .sw_sync      (sw_sync)
   );

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [PTR_W-1:0]             wr_ptr, rd_ptr;
   logic                         do_push, do_pop, drop;

   assign ready = (count != '0);
   assign full  = (count == CNT_W'(DEPTH));

   // A full FIFO still accepts a press when a pop frees the slot on the same
   // edge; an empty FIFO never bypasses the incoming word to the reader.
   assign do_pop  = rd_req && ready;
   assign do_push = press_evt && (!full || do_pop);
   assign drop    = press_evt && full && !do_pop;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         mem      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rd_valid <= do_pop;
         if (do_push) begin
            mem[wr_ptr] <= sw_sync;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture with an 8-cycle debounce and 4-deep FIFO.
module tb_input_capture;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          btn_n = 1'b1;
   logic [DW-1:0] switches_raw = '0;
   logic          rd_req = 1'b0;
   logic          clr_ovf = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, ready, full, overflow;
   logic [2:0]    count;

   int n_cmp = 0;
   int n_err = 0;

   input_capture #(
      .DATA_W(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .DEPTH(4)
   ) dut (
      .clk(clk), .n_reset(n_reset), .btn_n(btn_n), .switches_raw(switches_raw),
      .rd_req(rd_req), .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid),
      .ready(ready), .full(full), .overflow(overflow), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [DW-1:0] w);
      switches_raw = w;
      btn_n = 1'b0;
      tick(14);
      btn_n = 1'b1;
      tick(14);
   endtask

   task automatic chk_clear(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_flags"}, {28'd0, rd_valid, ready, full, overflow}, 0);
      chk({tag, "_data"}, 32'(rd_data), 0);
   endtask

   initial begin
      logic bad;
      logic [2:0] maxc;

      // reset and idle
      switches_raw = 16'hA5A5;
      tick(3);
      chk_clear("in_reset");
      n_reset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (count != 0 || rd_valid || ready || full || overflow || rd_data != 0) bad = 1'b1;
      end
      chk("idle50", 32'(bad), 0);

      // clean press, latency, single read
      switches_raw = 16'h1234;
      btn_n = 1'b0;
      tick(10);
      chk("lat_before", 32'(count), 0);
      tick();
      chk("lat_count", 32'(count), 1);
      chk("lat_ready", 32'(ready), 1);
      tick(29);
      chk("no_repeat", 32'(count), 1);
      btn_n = 1'b1;
      tick(15);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("rd1_valid", 32'(rd_valid), 1);
      chk("rd1_data", 32'(rd_data), 32'h1234);
      chk("rd1_count", 32'(count), 0);
      chk("rd1_ready", 32'(ready), 0);
      tick();
      chk("rd1_pulse", 32'(rd_valid), 0);

      // bouncing press and release
      switches_raw = 16'hBEEF;
      maxc = '0;
      for (int i = 0; i < 10; i++) begin
         btn_n = (i % 2 == 1);
         repeat (3) begin
            tick();
            if (count > maxc) maxc = count;
         end
      end
      chk("bounce_press", 32'(maxc), 0);
      btn_n = 1'b0;
      tick(14);
      chk("stable_press", 32'(count), 1);
      for (int i = 0; i < 10; i++) begin
         btn_n = (i % 2 == 0);
         tick(3);
      end
      btn_n = 1'b1;
      tick(14);
      chk("bounce_release", 32'(count), 1);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("bounce_data", 32'(rd_data), 32'hBEEF);

      // fill, overflow, ordered drain with rd_req held
      for (int k = 1; k <= 4; k++) press(DW'(k));
      chk("fill_count", 32'(count), 4);
      chk("fill_full", 32'(full), 1);
      chk("fill_ovf", 32'(overflow), 0);
      press(16'd5);
      chk("drop_count", 32'(count), 4);
      chk("drop_ovf", 32'(overflow), 1);
      rd_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("drain_valid%0d", k), 32'(rd_valid), 1);
         chk($sformatf("drain_data%0d", k), 32'(rd_data), k);
      end
      tick();
      rd_req = 1'b0;
      chk("empty_valid", 32'(rd_valid), 0);
      chk("empty_hold", 32'(rd_data), 4);
      chk("empty_ready", 32'(ready), 0);
      chk("ovf_sticky", 32'(overflow), 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_clear", 32'(overflow), 0);

      // push and pop on the same edge while full
      press(16'h11); press(16'h22); press(16'h33); press(16'h44);
      chk("full2", 32'(full), 1);
      switches_raw = 16'h55;
      btn_n = 1'b0;
      tick(10);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("sim_valid", 32'(rd_valid), 1);
      chk("sim_data", 32'(rd_data), 32'h11);
      chk("sim_count", 32'(count), 4);
      chk("sim_ovf", 32'(overflow), 0);
      btn_n = 1'b1;
      tick(14);
      rd_req = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk($sformatf("wrap_data%0d", k), 32'(rd_data), 32'(k * 16'h11));
      end
      rd_req = 1'b0;
      tick();
      chk("wrap_count", 32'(count), 0);

      // reset mid-debounce
      switches_raw = 16'h6666;
      btn_n = 1'b0;
      tick(6);
      n_reset = 1'b0;
      #2;
      chk_clear("rst_pw");
      btn_n = 1'b1;
      tick(2);
      n_reset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (count != 0 || rd_valid) bad = 1'b1;
      end
      chk("post_rst_quiet", 32'(bad), 0);

      // reset with three words queued, then mid-read
      press(16'hA1); press(16'hA2); press(16'hA3);
      chk("three", 32'(count), 3);
      n_reset = 1'b0;
      #2;
      chk_clear("rst_cnt3");
      tick();
      n_reset = 1'b1;
      press(16'h0077);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("pre_rst_valid", 32'(rd_valid), 1);
      n_reset = 1'b0;
      #2;
      chk_clear("rst_read");
      tick();
      n_reset = 1'b1;
      tick();
      chk("first_after_rst", {30'd0, rd_valid, ready}, 0);
      press(16'h0088);
      chk("new_count", 32'(count), 1);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("new_valid", 32'(rd_valid), 1);
      chk("new_data", 32'(rd_data), 32'h88);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/input_capture.md
Name: input_capture

Overview:
- Upstream input stage of the CPU. Conditions the raw "enter" push-button and the 16 board switches, and captures the switch word on each debounced press.
- Queues captured words in a small FIFO. Presents them to the control unit through a ready/request/valid handshake for input-type instructions.
- Replaces direct wiring of raw switches and the raw ready button into the core.

Parameters:
- DATA_W, 16, width of the switch word.
- SYNC_STAGES, 2, synchronizer flops on the button and switch inputs (minimum 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles required to accept a level change (minimum 2; benches use 8).
- DEPTH, 4, FIFO entries (power of two, minimum 2).

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- btn_n  in  1  raw button, active-low (0 = pressed), asynchronous.
- switches_raw  in  DATA_W  raw switch levels, asynchronous.
- rd_req  in  1  control unit pops one word (single-cycle pulse or level).
- clr_ovf  in  1  clears the sticky overflow flag.
- rd_data  out  DATA_W  popped word, registered.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
- ready  out  1  FIFO non-empty.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; a press was dropped while full.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: one clock; asynchronous, active-low.
  - n_reset low asynchronously clears all outputs to 0, empties the FIFO, forces the debounce FSM to RELEASED, and clears the debounce counter and synchronizers.
  - Asserting reset mid-debounce or mid-read discards everything. No push or rd_valid is produced in the first cycle after release.
- Synchronizers:
  - btn_n and switches_raw each pass through SYNC_STAGES flops. btn_s = inverted synchronized btn_n (1 = pressed).
- Debounce FSM, with counter cnt of width $clog2(DEBOUNCE_CYCLES)+1:
  - RELEASED: btn_s=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT: btn_s=0 -> RELEASED, cnt=0.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, and a push event fires on this edge.
    - Otherwise cnt+1.
  - PRESSED: btn_s=0 -> RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: btn_s=1 -> PRESSED, cnt=0.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> RELEASED.
    - Otherwise cnt+1.
  - Exactly one push per accepted press. Holding the button produces no repeats. Release produces no event.
- Latency: raw press held steady -> count increments SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first clk edge that sees btn_n low.
- Capture: the pushed word is the synchronized switch value in the cycle the FSM enters PRESSED.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr wrapping modulo DEPTH, plus an occupancy counter.
  - Push when not full: write and increment.
  - Push when full, with no pop in the same cycle: word dropped, overflow<=1, contents unchanged.
- Read:
  - rd_req=1 and count!=0 at an edge: pop. rd_data<=head and rd_valid<=1 on that edge, so rd_valid is visible the next cycle.
  - rd_req held high pops once per cycle while non-empty.
  - rd_req with count==0: no pop, rd_valid=0, rd_data holds its last value.
- Simultaneous push and pop:
  - When full: both occur, count stays DEPTH, no overflow.
  - When empty: push only, with no bypass; rd_valid=0 that cycle.
  - Otherwise: count unchanged.
- ready and full are decoded from the registered count. ready falls in the cycle after the last pop.
- overflow: set by a dropped push, cleared by clr_ovf. If both occur in the same cycle, set wins.

Decomposition:
- Shared package input_capture_pkg holds:
  - the debounce state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - the DATA_W/DEPTH default constants;
  - a clog2-based width helper.
- One sub-module, btn_debounce: synchronizer plus FSM. Outputs a single-cycle press_evt and the stable level.
- The FIFO and handshake live in the top block.

Test Plan (DEBOUNCE_CYCLES=8, DEPTH=4, SYNC_STAGES=2):
- Reset held, then released; switches=16'hA5A5, no press -> all outputs 0 and count=0 for 50 cycles.
- Clean press with switches=16'h1234, held 40 cycles, then rd_req pulse -> count=1 exactly 10 cycles after btn_n falls; ready=1; a single push; rd_valid pulse with rd_data=16'h1234; count=0.
- Bounce btn_n low/high every 3 cycles for 30 cycles, then held low -> no push during bouncing, exactly one push after stable low; a bouncing release creates no event.
- Five presses capturing 1, 2, 3, 4, 5 with no reads -> full=1 after 4; 5th dropped and overflow=1; four reads return 1, 2, 3, 4 in order; clr_ovf clears overflow.
- FIFO full, and a press accepted in the same cycle as rd_req -> rd_data=oldest word, new word enqueued, count stays 4, overflow stays 0; draining checks order across pointer wrap.
- n_reset asserted during PRESS_WAIT and with count=3 -> immediate clear; after release, no spurious push or rd_valid, and a new press behaves normally.
